regfile_hilo: RTL and testbench

//  Architectural state at the end of the 5-stage pipe: 32x32 GPR file plus HI/LO registers.

---
 rtl/regfile_hilo.sv | 102 ++++++++++
 tb/tb_regfile_hilo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_hilo.sv
// regfile_hilo: 32x32 GPR file plus HI/LO, committed from the writeback bus.
// Optional macro REGFILE_WB_BYPASS_EN adds same-cycle write-through on reads.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   wb_to_rf_bus      {md_hi_we, md_lo_we, md_hi, md_lo, mfhi, mflo, mthi, mtlo,
//                      rsvd[9:0], rf_we, rf_waddr, rf_wdata}
//   raddr1/raddr2     combinational GPR read addresses
//   rdata1/rdata2     GPR read data ($0 always reads zero)
//   hi_o/lo_o         current HI/LO values
module regfile_hilo #(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int WB_BUS_W = 118
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WB_BUS_W-1:0]        wb_to_rf_bus,
  input  logic [$clog2(REG_NUM)-1:0] raddr1,
  input  logic [$clog2(REG_NUM)-1:0] raddr2,
  output logic [DATA_W-1:0]          rdata1,
  output logic [DATA_W-1:0]          rdata2,
  output logic [DATA_W-1:0]          hi_o,
  output logic [DATA_W-1:0]          lo_o
);

  localparam int AW     = $clog2(REG_NUM);
  localparam int WE_B   = DATA_W + AW;
  localparam int HL_LSB = WE_B + 1;
  localparam int MD_LSB = HL_LSB + 14;

  logic [DATA_W-1:0] r_gpr [REG_NUM];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic [DATA_W-1:0] w_wdata;
  logic [AW-1:0]     w_waddr;
  logic              w_we;
  logic              w_mthi;
  logic              w_mtlo;
  logic [DATA_W-1:0] w_md_lo;
  logic [DATA_W-1:0] w_md_hi;
  logic              w_md_lo_we;
  logic              w_md_hi_we;
  logic              w_gpr_wen;
  logic              w_hi_wen;
  logic              w_lo_wen;
  logic [DATA_W-1:0] w_hi_nxt;
  logic [DATA_W-1:0] w_lo_nxt;
  logic              w_unused;

  assign w_wdata    = wb_to_rf_bus[DATA_W-1:0];
  assign w_waddr    = wb_to_rf_bus[WE_B-1:DATA_W];
  assign w_we       = wb_to_rf_bus[WE_B];
  assign w_mtlo     = wb_to_rf_bus[HL_LSB+10];
  assign w_mthi     = wb_to_rf_bus[HL_LSB+11];
  assign w_md_lo    = wb_to_rf_bus[MD_LSB+DATA_W-1:MD_LSB];
  assign w_md_hi    = wb_to_rf_bus[MD_LSB+2*DATA_W-1:MD_LSB+DATA_W];
  assign w_md_lo_we = wb_to_rf_bus[MD_LSB+2*DATA_W];
  assign w_md_hi_we = wb_to_rf_bus[MD_LSB+2*DATA_W+1];

  // mfhi/mflo and reserved bits carry no state change here.
  assign w_unused = ^{wb_to_rf_bus[HL_LSB+9:HL_LSB],
                      wb_to_rf_bus[HL_LSB+13:HL_LSB+12]};

  assign w_gpr_wen = w_we && (w_waddr != '0);

  // mul/div result outranks mthi/mtlo.
  assign w_hi_wen = w_md_hi_we | w_mthi;
  assign w_lo_wen = w_md_lo_we | w_mtlo;
  assign w_hi_nxt = w_md_hi_we ? w_md_hi : w_wdata;
  assign w_lo_nxt = w_md_lo_we ? w_md_lo : w_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) r_gpr[i] <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_gpr_wen) r_gpr[w_waddr] <= w_wdata;
      if (w_hi_wen)  r_hi <= w_hi_nxt;
      if (w_lo_wen)  r_lo <= w_lo_nxt;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : r_gpr[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : r_gpr[raddr2];
    hi_o   = r_hi;
    lo_o   = r_lo;
`ifdef REGFILE_WB_BYPASS_EN
    // Write-through; suppressed under reset so outputs show stored state.
    if (!rst) begin
      if (w_gpr_wen && raddr1 == w_waddr) rdata1 = w_wdata;
      if (w_gpr_wen && raddr2 == w_waddr) rdata2 = w_wdata;
      if (w_hi_wen) hi_o = w_hi_nxt;
      if (w_lo_wen) lo_o = w_lo_nxt;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_hilo.sv
// tb_regfile_hilo: randomized self-checking bench for regfile_hilo.
// Reference model is a plain array plus HI/LO variables.
module tb_regfile_hilo;

  logic         clk = 1'b0;
  logic         rst;
  logic [117:0] bus;
  logic [4:0]   ra1, ra2;
  logic [31:0]  rd1, rd2, hi, lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  regfile_hilo dut (
    .clk          (clk),
    .rst          (rst),
    .wb_to_rf_bus (bus),
    .raddr1       (ra1),
    .raddr2       (ra2),
    .rdata1       (rd1),
    .rdata2       (rd2),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  function automatic logic [117:0] mk(
    input logic hwe, input logic lwe,
    input logic [31:0] mhi, input logic [31:0] mlo,
    input logic [3:0] hl, input logic [9:0] rsvd,
    input logic we, input logic [4:0] wa, input logic [31:0] wd);
    return {hwe, lwe, mhi, mlo, hl, rsvd, we, wa, wd};
  endfunction

  // Apply one bus value across a clock edge and advance the model.
  task automatic step(input logic [117:0] b);
    bus = b;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 0;
      m_hi = 0;
      m_lo = 0;
    end else begin
      if (b[37] && b[36:32] != 0) m_gpr[b[36:32]] = b[31:0];
      if (b[117])     m_hi = b[115:84];
      else if (b[49]) m_hi = b[31:0];
      if (b[116])     m_lo = b[83:52];
      else if (b[48]) m_lo = b[31:0];
    end
    #1;
    bus = '0;
  endtask

  function automatic logic [31:0] mrd(input logic [4:0] a);
    return (a == 0) ? 32'h0 : m_gpr[a];
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    step(mk(1, 1, 32'h1234, 32'h5678, 4'b0011, 0, 1, 5'd4, 32'h99));
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_gpr a=%0d got %h/%h want 0", i, rd1, rd2);
      end
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
    end
  endtask

  task automatic test_gpr_write;
    step(mk(0, 0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF));
    ra1 = 5'd5;
    ra2 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL gpr5 got %h want deadbeef", rd1);
    end
    checks++;
    if (rd2 !== 32'h0) begin
      errors++;
      $display("FAIL gpr0_read got %h want 0", rd2);
    end
  endtask

  task automatic test_zero_write;
    step(mk(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h12345678));
    ra1 = 5'd0;
    ra2 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_write got %h/%h want 0", rd1, rd2);
    end
  endtask

  task automatic test_hilo_priority;
    step(mk(1, 1, 32'h1, 32'hFFFF0000, 4'b0011, 0, 0, 0, 32'hAAAA5555));
    #1;
    checks++;
    if (hi !== 32'h1 || lo !== 32'hFFFF0000) begin
      errors++;
      $display("FAIL hilo_prio got %h/%h want 1/ffff0000", hi, lo);
    end
  endtask

  task automatic test_mtlo_gpr;
    step(mk(0, 0, 0, 0, 4'b0001, 0, 1, 5'd9, 32'h00C0FFEE));
    ra1 = 5'd9;
    #1;
    checks++;
    if (lo !== 32'h00C0FFEE || rd1 !== 32'h00C0FFEE) begin
      errors++;
      $display("FAIL mtlo_gpr got lo=%h r9=%h want c0ffee", lo, rd1);
    end
    checks++;
    if (hi !== 32'h1) begin
      errors++;
      $display("FAIL mtlo_hi got %h want 1", hi);
    end
  endtask

  task automatic test_bypass;
    logic [31:0] exp;
    step(mk(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h11));
    bus = mk(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h55);
    ra1 = 5'd7;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    exp = 32'h55;
`else
    exp = mrd(5'd7);
`endif
    checks++;
    if (rd1 !== exp) begin
      errors++;
      $display("FAIL bypass got %h want %h", rd1, exp);
    end
    step(bus);
    ra1 = 5'd7;
    #1;
    checks++;
    if (rd1 !== 32'h55) begin
      errors++;
      $display("FAIL bypass_commit got %h want 55", rd1);
    end
  endtask

  task automatic test_bubble;
    for (int n = 0; n < 4; n++) begin
      step('0);
      ra1 = 5'd5;
      ra2 = 5'd9;
      #1;
      checks++;
      if (rd1 !== mrd(5'd5) || rd2 !== mrd(5'd9) ||
          hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL bubble got %h %h %h %h", rd1, rd2, hi, lo);
      end
    end
  endtask

  task automatic test_random;
    logic [117:0] b;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) b = '0;
      else b = mk(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  $urandom, $urandom, 4'($urandom), 10'($urandom),
                  1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom);
      step(b);
      ra1 = 5'($urandom);
      ra2 = (n % 5 == 0) ? ra1 : 5'($urandom);
      #1;
      checks++;
      if (rd1 !== mrd(ra1) || rd2 !== mrd(ra2)) begin
        errors++;
        $display("FAIL rand_gpr n=%0d a=%0d/%0d got %h/%h want %h/%h",
                 n, ra1, ra2, rd1, rd2, mrd(ra1), mrd(ra2));
      end
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL rand_hilo n=%0d got %h/%h want %h/%h",
                 n, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_reset_wins;
    step(mk(0, 0, 0, 0, 0, 0, 1, 5'd3, 32'hCAFE0003));
    rst = 1'b1;
    bus = mk(0, 0, 0, 0, 4'b0010, 0, 1, 5'd3, 32'hBAD0BAD0);
    ra1 = 5'd3;
    #1;
    checks++;
    if (rd1 !== 32'hCAFE0003 || hi !== m_hi) begin
      errors++;
      $display("FAIL rst_pending got %h/%h want cafe0003/%h",
               rd1, hi, m_hi);
    end
    step(bus);
    rst = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL rst_wins got %h %h %h want 0", rd1, hi, lo);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus = '0;
    ra1 = '0;
    ra2 = '0;
    for (int i = 0; i < 32; i++) m_gpr[i] = 0;
    m_hi = 0;
    m_lo = 0;
    @(posedge clk);
    #1;
    test_reset;
    test_gpr_write;
    test_zero_write;
    test_hilo_priority;
    test_mtlo_gpr;
    test_bypass;
    test_bubble;
    test_random;
    test_reset_wins;
    test_random;
    test_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
